// File: rtl/id_ex_stage_if.sv
// ID/EX boundary bundle: decoded control plus operands coming in from ID,
// registered copies going out to EX, and the PC / IF-ID stall enables going back.
interface id_ex_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
);
    logic              id_reg_dst, id_alu_src, id_mem_to_reg, id_reg_write;
    logic              id_mem_read, id_mem_write, id_beq, id_bne, id_bgtz;
    logic [1:0]        id_alu_op;
    logic [DATA_W-1:0] id_pc_plus4, id_rs_data, id_rt_data, id_imm;
    logic [REG_W-1:0]  id_rs, id_rt, id_rd;
    logic              flush, hold;

    logic              ex_reg_dst, ex_alu_src, ex_mem_to_reg, ex_reg_write;
    logic              ex_mem_read, ex_mem_write, ex_beq, ex_bne, ex_bgtz;
    logic [1:0]        ex_alu_op;
    logic [DATA_W-1:0] ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm;
    logic [REG_W-1:0]  ex_rs, ex_rt, ex_rd;
    logic              ex_valid;
    logic              pc_write, if_id_write;

    // Upstream pipeline / test driver side.
    modport master (
        output id_reg_dst, id_alu_src, id_mem_to_reg, id_reg_write,
               id_mem_read, id_mem_write, id_beq, id_bne, id_bgtz, id_alu_op,
               id_pc_plus4, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
               flush, hold,
        input  ex_reg_dst, ex_alu_src, ex_mem_to_reg, ex_reg_write,
               ex_mem_read, ex_mem_write, ex_beq, ex_bne, ex_bgtz, ex_alu_op,
               ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_rd,
               ex_valid, pc_write, if_id_write
    );

    // Pipeline register side.
    modport slave (
        input  id_reg_dst, id_alu_src, id_mem_to_reg, id_reg_write,
               id_mem_read, id_mem_write, id_beq, id_bne, id_bgtz, id_alu_op,
               id_pc_plus4, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
               flush, hold,
        output ex_reg_dst, ex_alu_src, ex_mem_to_reg, ex_reg_write,
               ex_mem_read, ex_mem_write, ex_beq, ex_bne, ex_bgtz, ex_alu_op,
               ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_rd,
               ex_valid, pc_write, if_id_write
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush/hold handling
// and saturating stall/flush event counters.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    id_ex_if.slave           bus,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef struct packed {
        logic              reg_dst;
        logic              alu_src;
        logic              mem_to_reg;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              beq;
        logic              bne;
        logic              bgtz;
        logic [1:0]        alu_op;
        logic [DATA_W-1:0] pc_plus4;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [REG_W-1:0]  rd;
        logic              valid;
    } ex_t;

    ex_t              ex_q, ex_d;
    ex_t              id_word, bubble_word;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             load_use;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + CNT_W'(1);
    endfunction

    // A load in EX whose destination is read by the ID instruction; $zero never hazards.
    assign load_use = ex_q.valid & ex_q.mem_read & (ex_q.rt != '0) &
                      ((ex_q.rt == bus.id_rs) | (ex_q.rt == bus.id_rt));

    // Flush wins over hold so a taken-branch redirect always lands.
    assign bus.pc_write    = bus.flush | (~bus.hold & ~load_use);
    assign bus.if_id_write = bus.flush | (~bus.hold & ~load_use);

    always_comb begin
        id_word.reg_dst    = bus.id_reg_dst;
        id_word.alu_src    = bus.id_alu_src;
        id_word.mem_to_reg = bus.id_mem_to_reg;
        id_word.reg_write  = bus.id_reg_write;
        id_word.mem_read   = bus.id_mem_read;
        id_word.mem_write  = bus.id_mem_write;
        id_word.beq        = bus.id_beq;
        id_word.bne        = bus.id_bne;
        id_word.bgtz       = bus.id_bgtz;
        id_word.alu_op     = bus.id_alu_op;
        id_word.pc_plus4   = bus.id_pc_plus4;
        id_word.rs_data    = bus.id_rs_data;
        id_word.rt_data    = bus.id_rt_data;
        id_word.imm        = bus.id_imm;
        id_word.rs         = bus.id_rs;
        id_word.rt         = bus.id_rt;
        id_word.rd         = bus.id_rd;
        id_word.valid      = 1'b1;
    end

    // A bubble keeps the operand data but carries no control and no valid bit.
    always_comb begin
        bubble_word            = id_word;
        bubble_word.reg_dst    = 1'b0;
        bubble_word.alu_src    = 1'b0;
        bubble_word.mem_to_reg = 1'b0;
        bubble_word.reg_write  = 1'b0;
        bubble_word.mem_read   = 1'b0;
        bubble_word.mem_write  = 1'b0;
        bubble_word.beq        = 1'b0;
        bubble_word.bne        = 1'b0;
        bubble_word.bgtz       = 1'b0;
        bubble_word.alu_op     = 2'b00;
        bubble_word.valid      = 1'b0;
    end

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        ex_d        = ex_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (bus.flush) begin
            ex_d        = bubble_word;
            flush_cnt_d = sat_inc(flush_cnt_q);
        end else if (bus.hold) begin
            ex_d = ex_q;
        end else if (load_use) begin
            ex_d        = bubble_word;
            stall_cnt_d = sat_inc(stall_cnt_q);
        end else begin
            ex_d = id_word;
        end
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.ex_reg_dst    = ex_q.reg_dst;
    assign bus.ex_alu_src    = ex_q.alu_src;
    assign bus.ex_mem_to_reg = ex_q.mem_to_reg;
    assign bus.ex_reg_write  = ex_q.reg_write;
    assign bus.ex_mem_read   = ex_q.mem_read;
    assign bus.ex_mem_write  = ex_q.mem_write;
    assign bus.ex_beq        = ex_q.beq;
    assign bus.ex_bne        = ex_q.bne;
    assign bus.ex_bgtz       = ex_q.bgtz;
    assign bus.ex_alu_op     = ex_q.alu_op;
    assign bus.ex_pc_plus4   = ex_q.pc_plus4;
    assign bus.ex_rs_data    = ex_q.rs_data;
    assign bus.ex_rt_data    = ex_q.rt_data;
    assign bus.ex_imm        = ex_q.imm;
    assign bus.ex_rs         = ex_q.rs;
    assign bus.ex_rt         = ex_q.rt;
    assign bus.ex_rd         = ex_q.rd;
    assign bus.ex_valid      = ex_q.valid;

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule
